// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and FSM state encoding for the decode-stage pipeline controller.
package pipe_ctrl_pkg;

   localparam int unsigned NREG_DEF  = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned PERF_W    = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN      = 2'd0;
   localparam state_t ST_REDIRECT = 2'd1;
   localparam state_t ST_DRAIN    = 2'd2;

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register pending-write counters with busy mask and sticky underflow error.
module pipe_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned NREG  = NREG_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_inc_en,
   input  logic [REG_IDX_W-1:0] i_inc_idx,
   input  logic                 i_dec_en,
   input  logic [REG_IDX_W-1:0] i_dec_idx,
   input  logic [REG_IDX_W-1:0] i_query_idx,
   output logic                 o_query_max,
   output logic                 o_all_zero,
   output logic [NREG-1:0]      o_busy_mask,
   output logic                 o_sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt     [NREG];
   logic [CNT_W-1:0] w_cnt_nxt [NREG];
   logic [NREG-1:0]  w_inc_hit;
   logic [NREG-1:0]  w_dec_hit;
   logic             w_dec_err;
   logic             r_sb_err;

   // Register 0 is hardwired: it never decodes as a hit.
   always_comb begin
      w_inc_hit = '0;
      w_dec_hit = '0;
      for (int i = 1; i < NREG; i++) begin
         w_inc_hit[i] = i_inc_en & (i_inc_idx == REG_IDX_W'(i));
         w_dec_hit[i] = i_dec_en & (i_dec_idx == REG_IDX_W'(i));
      end
   end

   // Simultaneous increment and decrement of one register cancel out.
   always_comb begin
      w_dec_err = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_inc_hit[i] && !w_dec_hit[i]) begin
            if (r_cnt[i] != CNT_MAX) begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end else if (w_dec_hit[i] && !w_inc_hit[i]) begin
            if (r_cnt[i] == '0) begin
               w_dec_err = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
         end
      end
      w_cnt_nxt[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_cnt[i] <= '0;
         end
         r_sb_err <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         if (w_dec_err) begin
            r_sb_err <= 1'b1;
         end
      end
   end

   always_comb begin
      o_busy_mask = '0;
      o_query_max = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         o_busy_mask[i] = (r_cnt[i] != '0);
         if (i_query_idx == REG_IDX_W'(i)) begin
            o_query_max = (r_cnt[i] == CNT_MAX);
         end
      end
   end

   assign o_all_zero = ~|o_busy_mask;
   assign o_sb_err   = r_sb_err;

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-stage hazard/stall/flush controller with scoreboard and drain handling.
// Optional perf counters (stall_cycles, flush_count) enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned NREG  = NREG_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_D,
   input  logic [4:0]      rs1_D,
   input  logic [4:0]      rs2_D,
   input  logic            use_rs1_D,
   input  logic            use_rs2_D,
   input  logic [4:0]      rd_D,
   input  logic            reg_write_D,
   input  logic            drain_req_D,
   input  logic            branch_taken_E,
   input  logic [4:0]      rd_W,
   input  logic            reg_write_W,
   output logic            stall_F,
   output logic            stall_D,
   output logic            flush_D,
   output logic            flush_E,
   output logic            issue_D,
   output logic            drain_done,
   output logic [NREG-1:0] busy_mask,
   output logic            sb_err
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
`endif
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_raw;
   logic            w_sat;
   logic            w_rd_max;
   logic            w_all_zero;
   logic            w_stall;
   logic            w_issue;
   logic            w_flush_d;
   logic            w_flush_e;
   logic            w_drain_done;
   logic            w_inc_en;
   logic            w_dec_en;
   logic [NREG-1:0] w_busy;

   pipe_scoreboard #(
      .CNT_W (CNT_W),
      .NREG  (NREG)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_inc_en    (w_inc_en),
      .i_inc_idx   (rd_D),
      .i_dec_en    (w_dec_en),
      .i_dec_idx   (rd_W),
      .i_query_idx (rd_D),
      .o_query_max (w_rd_max),
      .o_all_zero  (w_all_zero),
      .o_busy_mask (w_busy),
      .o_sb_err    (sb_err)
   );

   // Hazards are evaluated against the counters before this edge, so a
   // writeback releases its register only in the following cycle.
   assign w_raw = valid_D &
                  ((use_rs1_D & (rs1_D != 5'd0) & w_busy[rs1_D]) |
                   (use_rs2_D & (rs2_D != 5'd0) & w_busy[rs2_D]));
   assign w_sat = valid_D & reg_write_D & (rd_D != 5'd0) & w_rd_max;

   assign w_inc_en = w_issue & reg_write_D & (rd_D != 5'd0);
   assign w_dec_en = reg_write_W & (rd_W != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A taken branch overrides every state and every stall source.
   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_stall      = 1'b0;
      w_flush_d    = 1'b0;
      w_flush_e    = 1'b0;
      w_drain_done = 1'b0;
      if (branch_taken_E) begin
         w_flush_d   = 1'b1;
         w_flush_e   = 1'b1;
         w_state_nxt = ST_REDIRECT;
      end else begin
         case (r_state)
            ST_RUN: begin
               w_issue = valid_D & ~w_raw & ~w_sat & ~drain_req_D;
               w_stall = valid_D & ~w_issue;
               if (valid_D && drain_req_D) begin
                  w_state_nxt = ST_DRAIN;
               end
            end
            ST_REDIRECT: begin
               w_flush_d   = 1'b1;
               w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
               if (w_all_zero) begin
                  w_drain_done = 1'b1;
                  w_issue      = 1'b1;
                  w_state_nxt  = ST_RUN;
               end else begin
                  w_stall = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   assign stall_F    = w_stall;
   assign stall_D    = w_stall;
   assign flush_D    = w_flush_d;
   assign flush_E    = w_flush_e;
   assign issue_D    = w_issue;
   assign drain_done = w_drain_done;
   assign busy_mask  = w_busy;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] r_stall_cycles;
   logic [PERF_W-1:0] r_flush_count;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
         end
         if (w_flush_e && (r_flush_count != '1)) begin
            r_flush_count <= r_flush_count + PERF_W'(1);
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_D, use_rs1_D, use_rs2_D, reg_write_D, drain_req_D;
   logic        branch_taken_E, reg_write_W;
   logic [4:0]  rs1_D, rs2_D, rd_D, rd_W;
   logic        stall_F, stall_D, flush_D, flush_E, issue_D, drain_done, sb_err;
   logic [31:0] busy_mask;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_D(rd_D),
      .reg_write_D(reg_write_D), .drain_req_D(drain_req_D),
      .branch_taken_E(branch_taken_E), .rd_W(rd_W), .reg_write_W(reg_write_W),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
      .issue_D(issue_D), .drain_done(drain_done), .busy_mask(busy_mask), .sb_err(sb_err)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall, flush_d, flush_e, issue, done, err;
      logic [31:0] busy;
      logic [31:0] stc, flc;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: pending-write counts per register and controller mode.
   int   m_cnt[32];
   bit   m_err, m_redirect, m_draining, m_issued, m_stalled;
   int unsigned m_stallc, m_flushc;

   // Next-cycle stimulus.
   bit        s_rst, s_valid, s_u1, s_u2, s_rw, s_dr, s_br, s_rww;
   bit [4:0]  s_rs1, s_rs2, s_rd, s_rdw;

   function automatic bit mbusy(input bit [4:0] r);
      return (r != 5'd0) && (m_cnt[r] > 0);
   endfunction

   task automatic model_reset();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0; m_redirect = 0; m_draining = 0;
      m_stallc = 0; m_flushc = 0;
      m_issued = 0; m_stalled = 0;
   endtask

   task automatic clr();
      s_rst = 0; s_valid = 0; s_u1 = 0; s_u2 = 0; s_rw = 0; s_dr = 0;
      s_br = 0; s_rww = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_rdw = 0;
   endtask

   // Drive one cycle of stimulus, queue the expected response, advance the model.
   task automatic step();
      exp_t e;
      bit   raw, sat, inc, dec;
      @(posedge clk); #1;
      rst = s_rst; valid_D = s_valid; rs1_D = s_rs1; rs2_D = s_rs2;
      use_rs1_D = s_u1; use_rs2_D = s_u2; rd_D = s_rd; reg_write_D = s_rw;
      drain_req_D = s_dr; branch_taken_E = s_br; rd_W = s_rdw; reg_write_W = s_rww;
      if (s_rst) begin
         model_reset();
         return;
      end
      e.stall = 0; e.flush_d = 0; e.flush_e = 0; e.issue = 0; e.done = 0;
      e.err = m_err; e.stc = m_stallc; e.flc = m_flushc; e.busy = '0;
      for (int r = 1; r < 32; r++) e.busy[r] = (m_cnt[r] > 0);
      if (s_br) begin
         e.flush_d = 1; e.flush_e = 1;
         m_redirect = 1; m_draining = 0;
      end else if (m_redirect) begin
         e.flush_d = 1;
         m_redirect = 0;
      end else if (m_draining) begin
         if (e.busy == '0) begin
            e.done = 1; e.issue = 1; m_draining = 0;
         end else begin
            e.stall = 1;
         end
      end else begin
         raw = s_valid && ((s_u1 && mbusy(s_rs1)) || (s_u2 && mbusy(s_rs2)));
         sat = s_valid && s_rw && (s_rd != 0) && (m_cnt[s_rd] == 3);
         e.issue = s_valid && !raw && !sat && !s_dr;
         e.stall = s_valid && !e.issue;
         if (s_valid && s_dr) m_draining = 1;
      end
      inc = e.issue && s_rw && (s_rd != 0);
      dec = s_rww && (s_rdw != 0);
      if (!(inc && dec && s_rd == s_rdw)) begin
         if (inc) m_cnt[s_rd]++;
         if (dec) begin
            if (m_cnt[s_rdw] == 0) m_err = 1;
            else m_cnt[s_rdw]--;
         end
      end
      if (e.stall && m_stallc != 32'hFFFF_FFFF) m_stallc++;
      if (e.flush_e && m_flushc != 32'hFFFF_FFFF) m_flushc++;
      m_issued = e.issue; m_stalled = e.stall;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Monitor: every cycle the DUT presents a full output tuple for the queued vector.
   initial begin
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            ok = (stall_F === e.stall) && (stall_D === e.stall) &&
                 (flush_D === e.flush_d) && (flush_E === e.flush_e) &&
                 (issue_D === e.issue) && (drain_done === e.done) &&
                 (sb_err === e.err) && (busy_mask === e.busy);
`ifdef PIPE_CTRL_PERF_EN
            ok = ok && (stall_cycles === e.stc) && (flush_count === e.flc);
`endif
            if (!ok) begin
               n_bad++;
               $display("FAIL vec t=%0t: got stF=%b stD=%b flD=%b flE=%b iss=%b dd=%b err=%b busy=%h expected st=%b flD=%b flE=%b iss=%b dd=%b err=%b busy=%h",
                        $time, stall_F, stall_D, flush_D, flush_E, issue_D, drain_done, sb_err, busy_mask,
                        e.stall, e.flush_d, e.flush_e, e.issue, e.done, e.err, e.busy);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $finish;
   end

   task automatic do_reset();
      clr(); s_rst = 1; step(); step(); s_rst = 0;
   endtask

   task automatic iss(input bit [4:0] r);
      clr(); s_valid = 1; s_rd = r; s_rw = 1; step();
   endtask

   task automatic ret(input bit [4:0] r);
      clr(); s_rww = 1; s_rdw = r; step();
   endtask

   initial begin
      int infl[$];
      bit hold;
      clr(); s_rst = 1; model_reset();
      rst = 1; valid_D = 0; rs1_D = 0; rs2_D = 0; use_rs1_D = 0; use_rs2_D = 0;
      rd_D = 0; reg_write_D = 0; drain_req_D = 0; branch_taken_E = 0; rd_W = 0; reg_write_W = 0;

      // Reset state
      do_reset(); clr(); step();
      @(negedge clk);
      chk("reset_busy", busy_mask, 32'h0);
      chk("reset_err", {31'b0, sb_err}, 32'h0);

      // RAW on x5 holds until the cycle after its writeback
      iss(5);
      clr(); s_valid = 1; s_rs1 = 5; s_u1 = 1; step(); step();
      s_rww = 1; s_rdw = 5; step();
      @(negedge clk); chk("raw_wb_cycle_stall", {31'b0, stall_D}, 32'h1);
      s_rww = 0; step();
      @(negedge clk); chk("raw_release_issue", {31'b0, issue_D}, 32'h1);

      // x0 source never hazards, even with every other register busy
      for (int r = 1; r < 32; r++) iss(5'(r));
      clr(); s_valid = 1; s_u1 = 1; s_u2 = 1; step();
      @(negedge clk); chk("x0_src_issue", {31'b0, issue_D}, 32'h1);
      chk("x0_busy_mask", busy_mask, 32'hFFFF_FFFE);
      for (int r = 1; r < 32; r++) ret(5'(r));

      // Branch during RAW stall, then one REDIRECT cycle
      iss(6);
      clr(); s_valid = 1; s_rs1 = 6; s_u1 = 1; step();
      s_br = 1; step();
      @(negedge clk); chk("br_flush_e", {30'b0, flush_D, flush_E}, 32'h3);
      chk("br_stall", {31'b0, stall_D}, 32'h0);
      s_br = 0; step();
      @(negedge clk); chk("redirect_cycle", {29'b0, flush_D, flush_E, stall_D}, 32'h4);
      step(); ret(6);

      // Drain with x3 and x7 pending
      iss(3); iss(7);
      clr(); s_valid = 1; s_dr = 1; step(); step(); step();
      s_rww = 1; s_rdw = 3; step();
      s_rww = 0; step();
      s_rww = 1; s_rdw = 7; step();
      @(negedge clk); chk("drain_wait", {30'b0, drain_done, stall_D}, 32'h1);
      s_rww = 0; step();
      @(negedge clk); chk("drain_done_pulse", {29'b0, drain_done, issue_D, stall_D}, 32'h6);
      clr(); step();
      @(negedge clk); chk("drain_done_once", {31'b0, drain_done}, 32'h0);

      // Saturation on x9, cancelling inc/dec, then underflow error
      iss(9); iss(9); iss(9);
      clr(); s_valid = 1; s_rd = 9; s_rw = 1; step();
      @(negedge clk); chk("sat_stall", {31'b0, stall_D}, 32'h1);
      s_rww = 1; s_rdw = 9; step();
      step();
      @(negedge clk); chk("cancel_issue", {31'b0, issue_D}, 32'h1);
      ret(9); ret(9); ret(9);
      ret(4); clr(); step(); step();
      @(negedge clk); chk("sb_err_sticky", {31'b0, sb_err}, 32'h1);
      do_reset(); clr(); step();
      @(negedge clk); chk("sb_err_cleared", {31'b0, sb_err}, 32'h0);

      // Reset abandons DRAIN and REDIRECT
      iss(2);
      clr(); s_valid = 1; s_dr = 1; step(); step();
      do_reset(); clr(); step();
      @(negedge clk); chk("rst_mid_drain", {30'b0, drain_done, stall_D}, 32'h0);
      clr(); s_br = 1; step();
      do_reset(); clr(); step();
      @(negedge clk); chk("rst_mid_redirect", {31'b0, flush_D}, 32'h0);

      // Randomized traffic with in-order retirement of issued writes
      do_reset();
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!hold) begin
            s_valid = ($urandom_range(0, 9) < 8);
            s_rs1 = 5'($urandom_range(0, 7)); s_rs2 = 5'($urandom_range(0, 7));
            s_u1 = 1'($urandom); s_u2 = 1'($urandom);
            s_rd = 5'($urandom_range(0, 7)); s_rw = 1'($urandom);
            s_dr = ($urandom_range(0, 29) == 0);
         end
         s_br = ($urandom_range(0, 24) == 0);
         if (infl.size() > 0 && $urandom_range(0, 2) != 0) begin
            s_rww = 1; s_rdw = 5'(infl.pop_front());
         end else begin
            s_rww = 0; s_rdw = 5'($urandom_range(0, 31));
         end
         step();
         if (m_issued && s_rw && s_rd != 0) infl.push_back(int'(s_rd));
         hold = m_stalled;
      end

      clr(); step();
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk); @(negedge clk);
      if (q.size() != 0) begin
         n_vec++; n_bad++;
         $display("FAIL drain_queue: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (x0 included).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: valid_D  in  1  decode holds a valid instruction; rs1_D, rs2_D  in  5  source indices; use_rs1_D, use_rs2_D  in  1  source actually read.
REQ-005 SHALL have ports: rd_D  in  5  destination; reg_write_D  in  1  instruction writes rd; drain_req_D  in  1  decode holds fence/ecall requiring empty pipeline.
REQ-006 SHALL have ports: branch_taken_E  in  1  execute redirect; rd_W  in  5; reg_write_W  in  1  writeback retires a register write.
REQ-007 SHALL have ports: stall_F, stall_D, flush_D, flush_E, issue_D  out  1; drain_done  out  1; busy_mask  out  NREG  pending-write bit per register; sb_err  out  1  sticky scoreboard error.

Function
REQ-008 SHALL keep one CNT_W-bit counter per register; busy_mask[i] = (cnt[i] != 0); cnt[0] and busy_mask[0] always 0.
REQ-009 SHALL define raw = valid_D & ((use_rs1_D & rs1_D!=0 & busy[rs1_D]) | (use_rs2_D & rs2_D!=0 & busy[rs2_D])), combinational from current counters.
REQ-010 SHALL define sat = valid_D & reg_write_D & rd_D!=0 & cnt[rd_D]==max; sat is a structural stall.
REQ-011 SHALL implement FSM states RUN, REDIRECT, DRAIN; encoding in shared package.
REQ-012 In RUN: issue_D = valid_D & ~raw & ~sat & ~drain_req_D & ~branch_taken_E; stall_F = stall_D = valid_D & ~issue_D & ~branch_taken_E.
REQ-013 branch_taken_E (any state) SHALL assert flush_D and flush_E same cycle, force issue_D=0, go to REDIRECT; branch has priority over stall and drain.
REQ-014 REDIRECT SHALL last exactly one cycle: issue_D=0, stalls 0, flush_D=1, then RUN.
REQ-015 RUN with valid_D & drain_req_D & ~branch_taken_E SHALL go to DRAIN; DRAIN holds stall_F=stall_D=1, issue_D=0.
REQ-016 In DRAIN, when all counters zero (including decrement completing this edge visible next cycle), drain_done SHALL pulse one cycle with issue_D=1 (drain instruction issues), stalls 0, then RUN.
REQ-017 On clock edge: cnt[rd_D]++ if issue_D & reg_write_D & rd_D!=0; cnt[rd_W]-- if reg_write_W & rd_W!=0; same register both -> unchanged.
REQ-018 Decrement at zero SHALL leave counter 0 and set sb_err (sticky until reset); increment never wraps (guarded by REQ-010).
REQ-019 Writeback register SHALL remain busy during its W cycle (release visible next cycle); no internal bypass.

Reset
REQ-020 rst SHALL clear all counters, busy_mask=0, state=RUN, sb_err=0, drain_done=0; combinational outputs then follow inputs per RUN rules.
REQ-021 rst asserted mid-DRAIN or REDIRECT SHALL abandon it with no drain_done pulse.

Configuration
REQ-022 With PIPE_CTRL_PERF_EN defined: extra outputs stall_cycles, flush_count  out  32, cleared by reset, incremented on each stall_D / flush_E cycle, saturating at 0xFFFFFFFF.
REQ-023 Without PIPE_CTRL_PERF_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-024 Shared package pipe_ctrl_pkg SHALL hold FSM state typedef, NREG/register-index width constants.
REQ-025 Sub-module pipe_scoreboard SHALL hold counters, busy_mask, sb_err; pipe_ctrl holds FSM and stall/flush logic.

Verification
REQ-026 Issue addi x5 (rd=5, write) then next cycle valid_D, rs1=5 -> stall_D=1 until cycle after reg_write_W rd_W=5, then issue_D=1.
REQ-027 rs1_D=0, use_rs1_D=1 with busy_mask all ones except bit 0 -> stall_D=0, issue_D=1.
REQ-028 branch_taken_E=1 while raw stall active -> flush_D=flush_E=1, stall_D=0, next cycle REDIRECT, then RUN.
REQ-029 drain_req_D with x3,x7 pending -> stalls held until both retire, drain_done one-cycle pulse, issue_D=1 same cycle.
REQ-030 Three issues to x9 without reads (cnt=3), fourth -> stall_D=1 (sat); reg_write_W rd_W=9 with issue same cycle -> cnt stays 3; reg_write_W rd_W=4 with cnt[4]=0 -> sb_err=1 until rst.
